// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared micro-op type, ALU control codes and RV32I opcode constants
//
// Fields in uop_t carrying a datapath value (imm, tgt_imm, pc) are sized for
// the widest supported XLEN. Immediates are sign-extended across the whole
// field, so the low XLEN bits are always the XLEN-wide sign-extended value.
package decode_pkg;

    localparam int MAX_XLEN = 64;

    typedef struct packed {
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                rd_rs1;
        logic                rd_rs2;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                src_imm;
        logic                src_pc;
        logic [4:0]          alu_ctl;
        logic [MAX_XLEN-1:0] imm;
        logic [MAX_XLEN-1:0] tgt_imm;
        logic                is_br;
        logic [2:0]          br_f3;
        logic                is_jal;
        logic                is_jalr;
        logic                illegal;
        logic [MAX_XLEN-1:0] pc;
    } uop_t;

    localparam int UOP_W = $bits(uop_t);

    localparam logic [4:0] ALU_AND  = 5'd0;
    localparam logic [4:0] ALU_OR   = 5'd1;
    localparam logic [4:0] ALU_ADD  = 5'd2;
    localparam logic [4:0] ALU_XOR  = 5'd3;
    localparam logic [4:0] ALU_SLL  = 5'd4;
    localparam logic [4:0] ALU_SRL  = 5'd5;
    localparam logic [4:0] ALU_SUB  = 5'd6;
    localparam logic [4:0] ALU_SLT  = 5'd7;
    localparam logic [4:0] ALU_LUI  = 5'd10;
    localparam logic [4:0] ALU_SLTU = 5'd13;
    localparam logic [4:0] ALU_SRA  = 5'd15;
    localparam logic [4:0] ALU_MUL  = 5'd16;
    localparam logic [4:0] ALU_NONE = 5'd31;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Integer ALU operation selected by funct3; alt picks sub/sra over add/srl.
    function automatic logic [4:0] alu_of_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational RV32I(+M) instruction decoder producing a uop_t
//
// Ports:
//   instr  in   32    raw instruction word
//   pc     in   XLEN  PC of instr
//   uop    out  uop_t decoded micro-op
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output uop_t            uop
);

    logic [6:0]          opcode;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic [MAX_XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic                slli_ok, sr_ok;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // RV32 shift amounts are 5 bits, so bit 25 must be clear; RV64 uses 6 bits.
    assign slli_ok = (XLEN == 32) ? (f7 == 7'b0000000)
                                  : (instr[31:26] == 6'b000000);
    assign sr_ok   = (XLEN == 32) ? (f7 == 7'b0000000 || f7 == 7'b0100000)
                                  : (instr[31:26] == 6'b000000 || instr[31:26] == 6'b010000);

    always_comb begin
        logic ill;
        ill = 1'b0;
        uop = '0;

        uop.rs1       = instr[19:15];
        uop.rs2       = instr[24:20];
        uop.rd        = instr[11:7];
        uop.pc        = MAX_XLEN'(pc);
        uop.rd_rs1    = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        uop.rd_rs2    = (opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH);
        uop.src_imm   = (opcode != OP_OP);
        uop.src_pc    = (opcode == OP_AUIPC || opcode == OP_JAL || opcode == OP_JALR);
        uop.reg_write = 1'b1;
        uop.alu_ctl   = ALU_NONE;

        case (opcode)
            OP_LUI: begin
                uop.alu_ctl = ALU_LUI;
                uop.imm     = imm_u;
            end
            OP_AUIPC: begin
                uop.alu_ctl = ALU_ADD;
                uop.imm     = imm_u;
            end
            OP_JAL: begin
                uop.alu_ctl = ALU_ADD;
                uop.imm     = MAX_XLEN'(4);
                uop.tgt_imm = imm_j;
                uop.is_jal  = 1'b1;
            end
            OP_JALR: begin
                ill         = (f3 != 3'b000);
                uop.alu_ctl = ALU_ADD;
                uop.imm     = MAX_XLEN'(4);
                uop.tgt_imm = imm_i;
                uop.is_jalr = 1'b1;
            end
            OP_BRANCH: begin
                ill           = (f3 == 3'b010 || f3 == 3'b011);
                uop.reg_write = 1'b0;
                uop.tgt_imm   = imm_b;
                uop.is_br     = 1'b1;
                uop.br_f3     = f3;
            end
            OP_LOAD: begin
                ill          = (f3 != 3'b010);
                uop.alu_ctl  = ALU_ADD;
                uop.imm      = imm_i;
                uop.mem_read = 1'b1;
            end
            OP_STORE: begin
                ill           = (f3 != 3'b010);
                uop.alu_ctl   = ALU_ADD;
                uop.imm       = imm_s;
                uop.mem_write = 1'b1;
                uop.reg_write = 1'b0;
            end
            OP_IMM: begin
                uop.imm     = imm_i;
                uop.alu_ctl = alu_of_f3(f3, (f3 == 3'b101) && instr[30]);
                if (f3 == 3'b001)
                    ill = !slli_ok;
                else if (f3 == 3'b101)
                    ill = !sr_ok;
            end
            OP_OP: begin
                if (f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                    uop.alu_ctl = alu_of_f3(f3, f7[5]);
                else if (ENABLE_M != 0 && f7 == 7'b0000001)
                    uop.alu_ctl = ALU_MUL + {2'b00, f3};
                else
                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase

        // Illegal words still flow down the pipe, but must not change any state.
        if (ill) begin
            uop.illegal   = 1'b1;
            uop.alu_ctl   = ALU_NONE;
            uop.reg_write = 1'b0;
            uop.mem_read  = 1'b0;
            uop.mem_write = 1'b0;
            uop.is_br     = 1'b0;
            uop.is_jal    = 1'b0;
            uop.is_jalr   = 1'b0;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - decode stage with DEPTH-entry micro-op FIFO and jalr hold
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     fetch handshake; in_instr, in_pc carry the word
//   flush                 discard all queued uops and any jalr hold
//   jalr_done             execute resolved the outstanding jalr
//   out_valid/out_ready   issue handshake; out_uop is the head uop (0 when empty)
//   count                 occupied entries
module decode_queue
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int ENABLE_M = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_pc,
    input  logic                     flush,
    input  logic                     jalr_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output uop_t                     out_uop,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    uop_t          mem [DEPTH];
    uop_t          dec_uop;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count_q;
    logic          jalr_pending;
    logic          push, pop;

    decode_comb #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .uop   (dec_uop)
    );

    // in_ready depends only on registered state, so there is no
    // combinational out_ready -> in_ready path even when full.
    assign in_ready  = (count_q != FULL_CNT) && !jalr_pending;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign out_uop   = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push)
            mem[wr_ptr] <= dec_uop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            jalr_pending <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
            // A push is impossible while pending, so a jalr_done arriving with
            // nothing outstanding can never clear a freshly accepted jalr.
            if (push && dec_uop.is_jalr)
                jalr_pending <= 1'b1;
            else if (jalr_done)
                jalr_pending <= 1'b0;
        end
    end

endmodule
